seq_pattern_gen: RTL and testbench
==================================

# seq_pattern_gen

Serial pattern transmitter: sends a programmable PAT_W-bit pattern MSB-first on a single-bit line, repeated a requested number of times, with a programmable idle gap between repetitions. It is the stimulus/transmit side of the sequence-detector family. The default pattern 0011 drives a 0011 detector directly. It sits in front of detector blocks in sequence-detector test harnesses and on-chip self-test paths.

## Interface
- PAT_W, 4, pattern length in bits (≥2)
- PATTERN, 4'b0011, pattern register reset value
- CNT_W, 8, width of repetition count
- GAP_W, 4, width of gap length
- IDLE_LVL, 1'b1, level driven on x when no pattern bit is being sent

- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only when state is IDLE and rep_cnt≠0
- rep_cnt  in  CNT_W  number of pattern repetitions, sampled on accepted start
- gap_len  in  GAP_W  IDLE_LVL cycles between repetitions, sampled on accepted start; 0 = back-to-back
- pat_wr  in  1  load pat_in into pattern register; ignored unless IDLE
- pat_in  in  PAT_W  new pattern
- abort  in  1  terminate transfer; return to IDLE
- x  out  1  serial data, registered
- x_vld  out  1  high in every cycle a pattern bit is on x
- busy  out  1  high in SEND and GAP
- done  out  1  one-cycle pulse on normal completion

## Operation
- Reset values: x=IDLE_LVL, x_vld=0, busy=0, done=0, pattern register=PATTERN, state=IDLE, all counters 0.
- States: IDLE, SEND, GAP.
- IDLE:
  - start with rep_cnt≠0 → latch rep_cnt and gap_len, set bit index=PAT_W-1, go to SEND.
  - start with rep_cnt=0 → ignored; no busy, no done.
- SEND:
  - x=pattern[bit index], x_vld=1.
  - Bit index decrements each cycle.
  - After bit 0, decrement the remaining-repetition count.
  - If repetitions remain and gap_len≠0 → GAP. If repetitions remain and gap_len=0 → SEND with index reloaded, no bubble.
  - If no repetitions remain → IDLE with done=1 for one cycle.
- GAP: x=IDLE_LVL, x_vld=0, busy=1 for exactly gap_len cycles, then SEND with index reloaded.
- Pattern register is written only in IDLE. A pat_wr while busy is dropped; it is not queued.
- Simultaneous pat_wr+start in IDLE: the new pat_in is transmitted.
- abort has priority over everything except rst:
  - In SEND/GAP, next cycle is IDLE with x=IDLE_LVL, x_vld=0, busy=0, done=0.
  - In IDLE, abort suppresses a same-cycle start.
- rst mid-transfer: all outputs and the pattern register return to reset values at that edge; done is not pulsed.
- Counters are unsigned. The repetition counter decrements from rep_cnt to 0; no wrap.

## Timing
- start accepted at edge N → first bit (pattern MSB) on x in cycle N+1 (after edge N). busy rises at the same time.
- busy duration = rep_cnt·PAT_W + (rep_cnt−1)·gap_len cycles.
- done is high in the first cycle after the last bit. busy=0 in that cycle.
- A start in the done cycle is accepted. Back-to-back transfers have a minimum 1-cycle IDLE_LVL gap.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package seq_pkg holds:
  - state typedef: IDLE=2'b00, SEND=2'b01, GAP=2'b10
  - default pattern constant 4'b0011
  - IDLE_LVL default
- The package is shared with the detector blocks.
- Sub-module seq_pat_shifter: PAT_W-bit parallel-load, MSB-first shift register with load/shift enables. The top level holds the FSM, repetition counter and gap counter.

## Test plan
- Reset, then start, rep_cnt=1, gap_len=0, default pattern → x=0,0,1,1 in cycles 1–4, x_vld=1 for those 4 cycles, done in cycle 5, x=1 before and after.
- rep_cnt=2, gap_len=2 → x=0,0,1,1,1,1,0,0,1,1, busy 10 cycles, x_vld low only in the two gap cycles. A 0011 detector fed by x pulses y twice.
- rep_cnt=3, gap_len=0 → 12 contiguous valid bits 001100110011, single done.
- pat_wr with pat_in=4'b1010 during busy → current transfer unchanged. Same write in IDLE with start in the same cycle → x=1,0,1,0.
- abort in the 3rd SEND cycle → next cycle x=1, x_vld=0, busy=0, done never asserted. rst in the 2nd SEND cycle → all reset values, pattern back to 0011.
- start with rep_cnt=0 → no busy, no done. start+abort in IDLE → ignored. start in the done cycle → accepted, first bit in the next cycle.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the sequence generator/detector family.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SEND = 2'b01,
    GAP  = 2'b10
  } seq_state_e;

  localparam logic [3:0] SEQ_DEFAULT_PAT = 4'b0011;
  localparam logic       SEQ_IDLE_LVL    = 1'b1;

endpackage

// File: rtl/seq_pat_shifter.sv
// Parallel-load, MSB-first shift register; exposes the MSB it will hold after this edge.
module seq_pat_shifter #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             msb_nxt
);

  logic [PAT_W-1:0] sh_q, sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = din;
    end else if (shift) begin
      sh_d = {sh_q[PAT_W-2:0], 1'b0};
    end
  end

  assign msb_nxt = sh_d[PAT_W-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: programmable pattern sent MSB-first, repeated with an idle gap.
module seq_pattern_gen #(
  parameter int unsigned      PAT_W    = 4,
  parameter logic [PAT_W-1:0] PATTERN  = PAT_W'(seq_pkg::SEQ_DEFAULT_PAT),
  parameter int unsigned      CNT_W    = 8,
  parameter int unsigned      GAP_W    = 4,
  parameter logic             IDLE_LVL = seq_pkg::SEQ_IDLE_LVL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic [GAP_W-1:0] gap_len,
  input  logic             pat_wr,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             abort,
  output logic             x,
  output logic             x_vld,
  output logic             busy,
  output logic             done
);

  import seq_pkg::*;

  localparam int unsigned      IDX_W    = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] rem_q, rem_d, rem_dec;
  logic [GAP_W-1:0] glen_q, glen_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             x_q, x_d;
  logic             x_vld_q, x_vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             sh_load, sh_shift;
  logic [PAT_W-1:0] sh_din;
  logic             sh_msb_nxt;

  seq_pat_shifter #(.PAT_W(PAT_W)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load    (sh_load),
    .shift   (sh_shift),
    .din     (sh_din),
    .msb_nxt (sh_msb_nxt)
  );

  assign rem_dec = rem_q - CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    rem_d    = rem_q;
    glen_d   = glen_q;
    gcnt_d   = gcnt_q;
    pat_d    = pat_q;
    done_d   = 1'b0;
    sh_load  = 1'b0;
    sh_shift = 1'b0;
    sh_din   = pat_q;

    unique case (state_q)
      IDLE: begin
        if (!abort) begin
          // A same-cycle write feeds the shifter directly so the new pattern is sent.
          if (pat_wr) begin
            pat_d  = pat_in;
            sh_din = pat_in;
          end
          if (start && (rep_cnt != '0)) begin
            state_d = SEND;
            rem_d   = rep_cnt;
            glen_d  = gap_len;
            bit_d   = LAST_IDX;
            sh_load = 1'b1;
          end
        end
      end
      SEND: begin
        if (bit_q == '0) begin
          rem_d = rem_dec;
          if (rem_dec == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (glen_q != '0) begin
            state_d = GAP;
            gcnt_d  = glen_q;
          end else begin
            bit_d   = LAST_IDX;
            sh_load = 1'b1;
          end
        end else begin
          bit_d    = bit_q - IDX_W'(1);
          sh_shift = 1'b1;
        end
      end
      GAP: begin
        gcnt_d = gcnt_q - GAP_W'(1);
        if (gcnt_q == GAP_W'(1)) begin
          state_d = SEND;
          bit_d   = LAST_IDX;
          sh_load = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      done_d   = 1'b0;
      sh_load  = 1'b0;
      sh_shift = 1'b0;
      rem_d    = '0;
      gcnt_d   = '0;
      bit_d    = '0;
    end
  end

  always_comb begin
    x_vld_d = (state_d == SEND);
    busy_d  = (state_d != IDLE);
    x_d     = (state_d == SEND) ? sh_msb_nxt : IDLE_LVL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      rem_q   <= '0;
      glen_q  <= '0;
      gcnt_q  <= '0;
      pat_q   <= PATTERN;
      x_q     <= IDLE_LVL;
      x_vld_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      rem_q   <= rem_d;
      glen_q  <= glen_d;
      gcnt_q  <= gcnt_d;
      pat_q   <= pat_d;
      x_q     <= x_d;
      x_vld_q <= x_vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign x     = x_q;
  assign x_vld = x_vld_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed + random stimulus against a queue-based expansion model of the transmitter.
module tb_seq_pattern_gen;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned GAP_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] rep_cnt = '0;
  logic [GAP_W-1:0] gap_len = '0;
  logic             pat_wr = 1'b0;
  logic [PAT_W-1:0] pat_in = '0;
  logic             abort = 1'b0;
  logic             x, x_vld, busy, done;

  seq_pattern_gen #(
    .PAT_W    (PAT_W),
    .PATTERN  (4'b0011),
    .CNT_W    (CNT_W),
    .GAP_W    (GAP_W),
    .IDLE_LVL (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rep_cnt (rep_cnt),
    .gap_len (gap_len),
    .pat_wr  (pat_wr),
    .pat_in  (pat_in),
    .abort   (abort),
    .x       (x),
    .x_vld   (x_vld),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic x;
    logic vld;
    logic busy;
    logic done;
  } out_t;

  localparam out_t IDLE_OUT = '{x: 1'b1, vld: 1'b0, busy: 1'b0, done: 1'b0};

  out_t             cur = IDLE_OUT;
  out_t             fut[$];
  logic [PAT_W-1:0] m_pat = 4'b0011;
  int unsigned      total = 0;
  int unsigned      bad = 0;
  int unsigned      done_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // The accepted request becomes the full list of future output cycles.
  task automatic model_edge();
    logic [PAT_W-1:0] p;
    out_t             o;
    if (rst) begin
      fut.delete();
      cur   = IDLE_OUT;
      m_pat = 4'b0011;
    end else if (cur.busy) begin
      if (abort) begin
        fut.delete();
        cur = IDLE_OUT;
      end else begin
        cur = fut.pop_front();
      end
    end else if (abort) begin
      cur = IDLE_OUT;
    end else begin
      p = m_pat;
      if (pat_wr) begin
        p     = pat_in;
        m_pat = pat_in;
      end
      if (start && rep_cnt != 0) begin
        for (int r = 0; r < int'(rep_cnt); r++) begin
          for (int i = PAT_W - 1; i >= 0; i--) begin
            o = '{x: p[i], vld: 1'b1, busy: 1'b1, done: 1'b0};
            fut.push_back(o);
          end
          if (r < int'(rep_cnt) - 1) begin
            for (int g = 0; g < int'(gap_len); g++) begin
              o = '{x: 1'b1, vld: 1'b0, busy: 1'b1, done: 1'b0};
              fut.push_back(o);
            end
          end
        end
        o = '{x: 1'b1, vld: 1'b0, busy: 1'b0, done: 1'b1};
        fut.push_back(o);
        cur = fut.pop_front();
      end else begin
        cur = IDLE_OUT;
      end
    end
  endtask

  task automatic step(input logic s, input int unsigned rc, input int unsigned gl,
                      input logic pw, input logic [PAT_W-1:0] pi, input logic ab,
                      input logic rs);
    @(negedge clk);
    start   = s;
    rep_cnt = CNT_W'(rc);
    gap_len = GAP_W'(gl);
    pat_wr  = pw;
    pat_in  = pi;
    abort   = ab;
    rst     = rs;
    @(posedge clk);
    model_edge();
    #1;
    check("x", 32'(x), 32'(cur.x));
    check("x_vld", 32'(x_vld), 32'(cur.vld));
    check("busy", 32'(busy), 32'(cur.busy));
    check("done", 32'(done), 32'(cur.done));
    if (done) done_seen++;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) step(0, 0, 0, 0, '0, 0, 0);
  endtask

  initial begin
    int unsigned d0;
    step(0, 0, 0, 0, '0, 0, 1);
    step(0, 0, 0, 0, '0, 0, 1);
    idle(2);

    step(1, 1, 0, 0, '0, 0, 0);
    idle(6);
    step(1, 2, 2, 0, '0, 0, 0);
    idle(12);
    d0 = done_seen;
    step(1, 3, 0, 0, '0, 0, 0);
    idle(14);
    check("single_done_rep3", done_seen - d0, 1);

    step(1, 1, 0, 0, '0, 0, 0);
    step(0, 0, 0, 1, 4'b1010, 0, 0);
    idle(5);
    step(1, 1, 0, 1, 4'b1010, 0, 0);
    idle(6);

    d0 = done_seen;
    step(1, 2, 1, 0, '0, 0, 0);
    idle(2);
    step(0, 0, 0, 0, '0, 1, 0);
    idle(8);
    check("no_done_after_abort", done_seen - d0, 0);

    step(1, 2, 0, 1, 4'b1100, 0, 0);
    step(0, 0, 0, 0, '0, 0, 1);
    idle(2);
    step(1, 1, 0, 0, '0, 0, 0);
    idle(6);

    step(1, 0, 3, 0, '0, 0, 0);
    idle(2);
    step(1, 2, 1, 0, '0, 1, 0);
    idle(2);

    step(1, 1, 0, 0, '0, 0, 0);
    idle(4);
    step(1, 1, 1, 0, '0, 0, 0);
    idle(6);

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 3) == 0),
           $urandom_range(0, 3),
           $urandom_range(0, 3),
           ($urandom_range(0, 9) == 0),
           PAT_W'($urandom),
           ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 149) == 0));
    end
    idle(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
